// File: rtl/jtframe_irq_ctrl.sv
// jtframe_irq_ctrl: edge-latched interrupt sequencer driving 68000 IPL pins.
// Optional timeout on unacknowledged requests: define JTFRAME_IRQ_TMO_EN.
module jtframe_irq_ctrl #(
    parameter int W       = 7,
    parameter int HOLDOFF = 2,
    parameter int TMO     = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] sigedge,
    input  logic [W-1:0] mask,
    input  logic [W-1:0] clr,
    input  logic         iack,
    input  logic [2:0]   iack_lvl,
    output logic [2:0]   ipl_n,
    output logic [W-1:0] pending,
    output logic         busy,
    output logic         tmo_flag
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t       st, st_nx;
    logic [W-1:0] last, rise, qual, drop, sw_clr;
    logic [2:0]   cand, cur_lvl, lvl_nx, ipl_nx;
    logic [3:0]   hcnt, hcnt_nx;
    logic         ack, hit;

    assign rise   = sigedge & ~last;
    assign qual   = pending & ~mask;
    assign sw_clr = cen ? clr : '0;
    assign ack    = cen && (st == REQ) && iack && (iack_lvl == cur_lvl);
    assign busy   = (st == REQ) || (st == HOLD);

`ifdef JTFRAME_IRQ_TMO_EN
    logic [15:0] tcnt;

    assign hit = cen && (st == REQ) && !ack && (tcnt == 16'(TMO - 1));

    // Count cens spent waiting in REQ; flag sticks once a request times out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= '0;
            tmo_flag <= 1'b0;
        end else if (cen) begin
            tcnt <= (st == REQ) ? tcnt + 16'd1 : 16'd0;
            if (hit) tmo_flag <= 1'b1;
        end
    end
`else
    // No timeout: TMO is at least 1, so both terms stay low
    assign hit      = 1'b0;
    assign tmo_flag = (TMO < 1);
`endif

    // Highest qualifying source wins; level is index+1, 0 when none
    always_comb begin
        cand = 3'd0;
        for (int i = 0; i < W; i++) begin
            if (qual[i]) cand = 3'(i + 1);
        end
    end

    // One-hot clear of the level being retired by iack or timeout
    always_comb begin
        drop = '0;
        for (int i = 0; i < W; i++) begin
            if ((ack || hit) && (cur_lvl == 3'(i + 1))) drop[i] = 1'b1;
        end
    end

    // Edge capture every clk; clears override a same-cycle edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= '1;
            pending <= '0;
        end else begin
            last    <= sigedge;
            pending <= (pending | rise) & ~drop & ~sw_clr;
        end
    end

    // Next-state and registered IPL value, advancing only on cen
    always_comb begin
        st_nx   = st;
        lvl_nx  = cur_lvl;
        hcnt_nx = hcnt;
        ipl_nx  = ipl_n;
        if (cen) begin
            unique case (st)
                IDLE: begin
                    ipl_nx = 3'b111;
                    if (cand != 3'd0) begin
                        lvl_nx = cand;
                        ipl_nx = ~cand;
                        st_nx  = REQ;
                    end
                end
                REQ: begin
                    if (ack || hit) begin
                        ipl_nx  = 3'b111;
                        hcnt_nx = 4'(HOLDOFF - 1);
                        st_nx   = HOLD;
                    end else if (cand == 3'd0) begin
                        ipl_nx = 3'b111;
                        st_nx  = IDLE;
                    end else if (cand > cur_lvl) begin
                        lvl_nx = cand;
                        ipl_nx = ~cand;
                    end
                end
                HOLD: begin
                    ipl_nx = 3'b111;
                    if (hcnt == 4'd0) st_nx = IDLE;
                    else hcnt_nx = hcnt - 4'd1;
                end
                default: begin
                    ipl_nx = 3'b111;
                    st_nx  = IDLE;
                end
            endcase
        end
    end

    // State, current level, holdoff counter and IPL registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            cur_lvl <= 3'd0;
            hcnt    <= 4'd0;
            ipl_n   <= 3'b111;
        end else begin
            st      <= st_nx;
            cur_lvl <= lvl_nx;
            hcnt    <= hcnt_nx;
            ipl_n   <= ipl_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_irq_ctrl.sv
// tb_jtframe_irq_ctrl: scoreboard bench for jtframe_irq_ctrl.
// Timeout scenarios are modelled when JTFRAME_IRQ_TMO_EN is defined.
module tb_jtframe_irq_ctrl;

    localparam int W       = 7;
    localparam int HOLDOFF = 2;
    localparam int TMO     = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cen = 1'b0;
    logic [W-1:0] sigedge = '0;
    logic [W-1:0] mask = '0;
    logic [W-1:0] clr = '0;
    logic         iack = 1'b0;
    logic [2:0]   iack_lvl = 3'd0;
    logic [2:0]   ipl_n;
    logic [W-1:0] pending;
    logic         busy;
    logic         tmo_flag;

    jtframe_irq_ctrl #(
        .W(W),
        .HOLDOFF(HOLDOFF),
        .TMO(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cen(cen),
        .sigedge(sigedge),
        .mask(mask),
        .clr(clr),
        .iack(iack),
        .iack_lvl(iack_lvl),
        .ipl_n(ipl_n),
        .pending(pending),
        .busy(busy),
        .tmo_flag(tmo_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   ipl_n;
        logic [W-1:0] pend;
        logic         busy;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: presented level (0 = none), cens left in holdoff
    logic [W-1:0] m_prev, m_pend;
    int           m_lvl, m_hold, cen_idx, arm_at;
    bit           m_tmo;

    function automatic int top_level(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_prev  = '1;
        m_pend  = '0;
        m_lvl   = 0;
        m_hold  = 0;
        m_tmo   = 1'b0;
        cen_idx = 0;
        arm_at  = 0;
    endtask

    // Predict the state after the coming clk edge and queue it
    task automatic model_step();
        logic [W-1:0] nx;
        int           cand;
        bit           ack;
        bit           hit;
        exp_t         e;
        cand   = top_level(m_pend & ~mask);
        nx     = m_pend | (sigedge & ~m_prev);
        m_prev = sigedge;
        if (cen) begin
            cen_idx++;
            ack = (m_lvl != 0) && iack && (int'(iack_lvl) == m_lvl);
            hit = 1'b0;
`ifdef JTFRAME_IRQ_TMO_EN
            hit = (m_lvl != 0) && !ack && (cen_idx - arm_at == TMO);
`endif
            if (ack || hit) begin
                nx[m_lvl-1] = 1'b0;
                m_lvl       = 0;
                m_hold      = HOLDOFF;
                if (hit) m_tmo = 1'b1;
            end else if (m_lvl != 0) begin
                if (cand == 0) m_lvl = 0;
                else if (cand > m_lvl) m_lvl = cand;
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (cand > 0) begin
                m_lvl  = cand;
                arm_at = cen_idx;
            end
            nx = nx & ~clr;
        end
        m_pend  = nx;
        e.ipl_n = ~3'(m_lvl);
        e.pend  = m_pend;
        e.busy  = (m_lvl != 0) || (m_hold > 0);
        e.tmo   = m_tmo;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs just after each edge
    always @(posedge clk) begin
        #2;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({ipl_n, pending, busy, tmo_flag} !== mon_e) begin
                failures++;
                $display("FAIL step t=%0t ipl_n=%b want %b pending=%h want %h busy=%b want %b tmo=%b want %b",
                         $time, ipl_n, mon_e.ipl_n, pending, mon_e.pend,
                         busy, mon_e.busy, tmo_flag, mon_e.tmo);
            end
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Asynchronous reset: outputs must clear with no clk edge
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        checks++;
        if ({ipl_n, pending, busy, tmo_flag} !== {3'b111, {W{1'b0}}, 2'b00}) begin
            failures++;
            $display("FAIL async_reset ipl_n=%b pending=%h busy=%b tmo=%b want 111/0/0/0",
                     ipl_n, pending, busy, tmo_flag);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        cen     = 1'b1;
        sigedge = 7'h04;
        @(negedge clk);
        do_reset();
        ticks(3);
        sigedge[2] = 1'b0;
        tick();
        sigedge[2] = 1'b1;
        ticks(4);
        iack = 1'b1; iack_lvl = 3'd3; tick(); iack = 1'b0;
        ticks(5);
        sigedge = 7'h16;
        ticks(4);
        iack = 1'b1; iack_lvl = 3'd5; tick(); iack = 1'b0;
        ticks(5);
        sigedge = 7'h36;
        ticks(4);
        iack = 1'b1; iack_lvl = 3'd2; tick(); iack = 1'b0;
        tick();
        iack = 1'b1; iack_lvl = 3'd6; tick(); iack = 1'b0;
        ticks(5);
        iack = 1'b1; iack_lvl = 3'd2; tick(); iack = 1'b0;
        ticks(5);
        sigedge = 7'h00;
        tick();
        sigedge = 7'h08;
        ticks(4);
        mask = 7'h08;
        ticks(3);
        mask = 7'h00;
        ticks(4);
        iack = 1'b1; iack_lvl = 3'd4; tick(); iack = 1'b0;
        ticks(5);
        sigedge = 7'h09;
        ticks(4);
        sigedge = 7'h08;
        tick();
        sigedge = 7'h09; clr = 7'h01; iack = 1'b1; iack_lvl = 3'd1;
        tick();
        clr = '0; iack = 1'b0;
        tick();
        do_reset();
        ticks(3);
`ifdef JTFRAME_IRQ_TMO_EN
        sigedge = 7'h00;
        tick();
        sigedge = 7'h01;
        ticks(TMO + 8);
`endif
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cen = ($urandom_range(3) != 0);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(5) == 0) sigedge[b] = ~sigedge[b];
            end
            if ($urandom_range(15) == 0) mask = W'($urandom) & W'($urandom);
            clr = ($urandom_range(19) == 0) ? W'(1 << $urandom_range(W - 1)) : '0;
            iack = ($urandom_range(5) == 0);
            if (m_lvl != 0 && $urandom_range(3) != 0) iack_lvl = 3'(m_lvl);
            else iack_lvl = 3'($urandom_range(7));
            tick();
        end
        cen  = 1'b1;
        iack = 1'b0;
        clr  = '0;
        tick();
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
